// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core definitions.
//   XLEN            - architectural register width.
//   alu_op_e        - ALU/M-extension operation select driven by the decoder.
//   muldiv_state_e  - sequencing states of muldiv_unit.
//   DIV_CYCLES      - start-to-done latency of a regular (non special-case) divide.
//   is_mul_op/is_div_op - classify an alu_op_e as an M-extension multiply/divide.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_LUI,
    ALU_MUL,
    ALU_MULH,
    ALU_MULHSU,
    ALU_MULHU,
    ALU_DIV,
    ALU_DIVU,
    ALU_REM,
    ALU_REMU
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIXUP
  } muldiv_state_e;

  // Accept cycle + XLEN iterations + one sign fix-up cycle.
  localparam int DIV_CYCLES = XLEN + 2;

  function automatic logic is_mul_op(input alu_op_e op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// div_core: iterative unsigned restoring divider, one quotient bit per cycle.
//   clk, rst     - clock, asynchronous active-high reset.
//   start_i      - load dividend_i/divisor_i and begin XLEN iterations.
//   abort_i      - drop any in-flight division (wins over start_i).
//   dividend_i   - unsigned dividend.
//   divisor_i    - unsigned divisor (must be non-zero; zero is handled upstream).
//   done_o       - high during the final iteration; quotient_o/remainder_o are
//                  final from the following cycle until the next start_i.
//   quotient_o   - quotient register.
//   remainder_o  - partial / final remainder register.
module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN);

  logic            active_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;

  // rem_q < divisor always holds, so the shifted remainder fits in XLEN+1 bits
  // and a set diff[XLEN] means the trial subtraction borrowed.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_q};
  end

  assign done_o      = active_q && (cnt_q == CW'(XLEN - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (abort_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= dividend_i;
      dvs_q    <= divisor_i;
    end else if (active_q) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      if (cnt_q == CW'(XLEN - 1)) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execution unit beside the EX-stage ALU.
//   clk, rst  - clock, asynchronous active-high reset.
//   start     - request, sampled only while busy=0.
//   op        - M-extension operation, sampled with start.
//   rs1_val   - dividend / multiplicand, sampled with start.
//   rs2_val   - divisor / multiplier, sampled with start.
//   flush     - abort any in-flight operation; also blocks a same-cycle start.
//   busy      - operation in flight (state != IDLE); EX stalls while high.
//   done      - one-cycle pulse, result valid this cycle.
//   result    - last completed result, held until the next done.
//
// Handshake: an operation is accepted in the cycle where start=1, busy=0,
// flush=0 and op is an M op (cycle 0). Non-M ops and requests made while busy
// are dropped silently. The result arrives with a single done pulse, during
// which busy is already low, so the next start may be issued in that cycle.
module muldiv_unit #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int MUL_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  riscv_pkg::alu_op_e  op,
  input  logic [XLEN-1:0]     rs1_val,
  input  logic [XLEN-1:0]     rs2_val,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     result
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q;
  alu_op_e         op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [2:0]      mul_cnt_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            is_mul, is_div, accept;
  logic            div_signed, div_is_rem, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res, dvd_abs, dvs_abs;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  alu_op_e           mul_op;
  logic [XLEN-1:0]   mul_a, mul_b;
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_ea, mul_eb, prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   q_fix, r_fix, fix_res;

  // Accept decode and divide special cases, evaluated on the live inputs.
  always_comb begin
    is_mul     = is_mul_op(op);
    is_div     = is_div_op(op);
    accept     = start && !flush && (state_q == IDLE) && (is_mul || is_div);
    div_signed = (op == ALU_DIV) || (op == ALU_REM);
    div_is_rem = (op == ALU_REM) || (op == ALU_REMU);
    div_zero   = (rs2_val == '0);
    div_ovf    = div_signed && (rs1_val == MIN_NEG) && (rs2_val == '1);
    special    = is_div && (div_zero || div_ovf);
    if (div_zero) special_res = div_is_rem ? rs1_val : '1;
    else          special_res = div_is_rem ? '0 : MIN_NEG;
    dvd_abs    = (div_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    dvs_abs    = (div_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
    div_start  = accept && is_div && !special;
  end

  // Multiplier reads the live operands in IDLE (single-cycle latency) and the
  // captured operands otherwise. The 2*XLEN-bit extension is exact modulo
  // 2^(2*XLEN), which covers every bit any MUL* variant returns.
  always_comb begin
    mul_op  = (state_q == IDLE) ? op : op_q;
    mul_a   = (state_q == IDLE) ? rs1_val : a_q;
    mul_b   = (state_q == IDLE) ? rs2_val : b_q;
    mul_sa  = (mul_op == ALU_MULH) || (mul_op == ALU_MULHSU);
    mul_sb  = (mul_op == ALU_MULH);
    mul_ea  = {{XLEN{mul_sa & mul_a[XLEN-1]}}, mul_a};
    mul_eb  = {{XLEN{mul_sb & mul_b[XLEN-1]}}, mul_b};
    prod    = mul_ea * mul_eb;
    mul_res = (mul_op == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Sign restoration of the unsigned divider outputs.
  always_comb begin
    q_fix   = q_neg_q ? -div_quo : div_quo;
    r_fix   = r_neg_q ? -div_rem : div_rem;
    fix_res = ((op_q == ALU_REM) || (op_q == ALU_REMU)) ? r_fix : q_fix;
  end

  div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .abort_i     (flush),
    .dividend_i  (dvd_abs),
    .divisor_i   (dvs_abs),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      mul_cnt_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q   <= IDLE;
        mul_cnt_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept) begin
              op_q <= op;
              if (is_mul) begin
                if (MUL_CYCLES == 1) begin
                  result_q <= mul_res;
                  done_q   <= 1'b1;
                end else begin
                  a_q       <= rs1_val;
                  b_q       <= rs2_val;
                  mul_cnt_q <= 3'd1;
                  state_q   <= MUL;
                end
              end else if (special) begin
                result_q <= special_res;
                done_q   <= 1'b1;
              end else begin
                q_neg_q <= div_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
                r_neg_q <= div_signed && rs1_val[XLEN-1];
                state_q <= DIV;
              end
            end
          end
          MUL: begin
            if (mul_cnt_q == 3'(MUL_CYCLES - 1)) begin
              result_q  <= mul_res;
              done_q    <= 1'b1;
              mul_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              mul_cnt_q <= mul_cnt_q + 3'd1;
            end
          end
          DIV: begin
            if (div_done) state_q <= FIXUP;
          end
          FIXUP: begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import riscv_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 2;

  logic          clk, rst, start, flush, busy, done;
  alu_op_e       op;
  logic [W-1:0]  rs1_val, rs2_val, result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Scoreboard: one entry per accepted operation.
  logic [W-1:0] exp_q[$];
  int           st_q[$];
  int           dn_q[$];
  bit           cx_q[$];
  logic [W-1:0] m_result = '0;

  muldiv_unit #(.XLEN(W), .MUL_CYCLES(MUL_LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Architectural result of an M op, straight from the ISA definition.
  function automatic logic [W-1:0] model_val(alu_op_e o, logic [W-1:0] a, logic [W-1:0] b);
    logic [2*W-1:0] pu;
    longint         ps;
    case (o)
      ALU_MUL:    begin pu = {32'b0, a} * {32'b0, b}; return pu[W-1:0]; end
      ALU_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; return pu[2*W-1:W]; end
      ALU_MULH:   begin ps = longint'($signed(a)) * longint'($signed(b)); return ps[63:32]; end
      ALU_MULHSU: begin ps = longint'($signed(a)) * longint'({32'b0, b}); return ps[63:32]; end
      ALU_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      ALU_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      ALU_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return '0;
    endcase
  endfunction

  function automatic int model_lat(alu_op_e o, logic [W-1:0] a, logic [W-1:0] b);
    if (is_mul_op(o)) return MUL_LAT;
    if (b == 0) return 1;
    if ((o == ALU_DIV || o == ALU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return DIV_CYCLES;
  endfunction

  function automatic bit model_busy(int c);
    bit bz = 1'b0;
    foreach (st_q[i]) if (st_q[i] < c && c < dn_q[i]) bz = 1'b1;
    return bz;
  endfunction

  task automatic pop_all();
    void'(exp_q.pop_front());
    void'(st_q.pop_front());
    void'(dn_q.pop_front());
    void'(cx_q.pop_front());
  endtask

  task automatic clear_all();
    exp_q.delete(); st_q.delete(); dn_q.delete(); cx_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; the request is sampled at the next edge.
  task automatic issue(input alu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b, input bit fl);
    op = o; rs1_val = a; rs2_val = b; start = 1'b1; flush = fl;
    if (!fl && !model_busy(cyc) && (is_mul_op(o) || is_div_op(o))) begin
      exp_q.push_back(model_val(o, a, b));
      st_q.push_back(cyc);
      dn_q.push_back(cyc + model_lat(o, a, b));
      cx_q.push_back(1'b0);
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    // Scramble the inputs to show the unit works from captured operands.
    op = ALU_SUB; rs1_val = $urandom; rs2_val = $urandom;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    foreach (st_q[i])
      if (!cx_q[i] && st_q[i] < cyc && cyc < dn_q[i]) begin
        cx_q[i] = 1'b1;
        dn_q[i] = cyc + 1;
      end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("wait_idle_timeout", 32'(exp_q.size()), 32'd0);
      clear_all();
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_done;
    exp_busy = model_busy(cyc);
    while (cx_q.size() > 0 && cx_q[0] && dn_q[0] <= cyc) pop_all();
    exp_done = (exp_q.size() > 0) && !cx_q[0] && (dn_q[0] == cyc);
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("done", {31'b0, done}, {31'b0, exp_done});
    if (exp_done) begin
      m_result = exp_q[0];
      pop_all();
    end
    chk("result", result, m_result);
  end

  // ---------------- stimulus ----------------
  alu_op_e      t_op[8] = '{ALU_DIV, ALU_REM, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU, ALU_MULHSU, ALU_MUL};
  logic [W-1:0] t_a[8]  = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd20, 32'd20, 32'hFFFFFFFF, 32'd1000, 32'h80000000, 32'h12345678};
  logic [W-1:0] t_b[8]  = '{32'd3, 32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd1, 32'd7, 32'd2, 32'h9ABCDEF0};

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = ALU_ADD; rs1_val = '0; rs2_val = '0;
    wait_cycles(2);
    chk("reset_busy",   {31'b0, busy}, 32'd0);
    chk("reset_done",   {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    // Hand-computed values that pin the model.
    chk("pin_mul",    model_val(ALU_MUL,    32'd7,        32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("pin_mulhu",  model_val(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("pin_mulh",   model_val(ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF), 32'h00000000);
    chk("pin_mulhsu", model_val(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    chk("pin_div",    model_val(ALU_DIV,    32'hFFFFFFF9, 32'd2),        32'hFFFFFFFD);
    chk("pin_rem",    model_val(ALU_REM,    32'hFFFFFFF9, 32'd2),        32'hFFFFFFFF);
    chk("pin_divu",   model_val(ALU_DIVU,   32'd100,      32'd7),        32'd14);
    chk("pin_divu0",  model_val(ALU_DIVU,   32'd5,        32'd0),        32'hFFFFFFFF);
    chk("pin_remu0",  model_val(ALU_REMU,   32'd5,        32'd0),        32'd5);
    chk("pin_divovf", model_val(ALU_DIV,    32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    chk("pin_removf", model_val(ALU_REM,    32'h80000000, 32'hFFFFFFFF), 32'd0);
    chk("pin_div_neg", model_val(ALU_DIV,   32'hFFFFFFEC, 32'd3),        32'hFFFFFFFA);
    chk("pin_rem_neg", model_val(ALU_REM,   32'hFFFFFFEC, 32'd3),        32'hFFFFFFFE);
    chk("pin_lat_div", 32'(model_lat(ALU_DIV, 32'd7, 32'd2)), 32'd34);

    // Multiplies.
    issue(ALU_MUL,    32'd7,        32'hFFFFFFFD, 1'b0); wait_idle();
    issue(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_idle();
    issue(ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_idle();
    issue(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_idle();

    // Divide, then REM with a DIVU issued in its done cycle.
    issue(ALU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0); wait_idle();
    issue(ALU_REM, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_cycles(33);
    issue(ALU_DIVU, 32'd100, 32'd7, 1'b0); wait_idle();
    chk("divu_b2b_result", result, 32'd14);

    // Special cases, issued every cycle.
    issue(ALU_DIVU, 32'd5,        32'd0,        1'b0);
    issue(ALU_REMU, 32'd5,        32'd0,        1'b0);
    issue(ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0);
    issue(ALU_REM,  32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle();

    // Mixed signs and operand extremes.
    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b0);
      wait_idle();
    end

    // Non-M op is ignored.
    issue(ALU_ADD, 32'd1, 32'd2, 1'b0);
    wait_cycles(3);

    // Flush in cycle 10 of a divide.
    issue(ALU_DIV, 32'd1000, 32'd3, 1'b0);
    wait_cycles(9);
    do_flush();
    wait_idle();
    wait_cycles(40);

    // start together with flush is dropped.
    issue(ALU_DIVU, 32'd9, 32'd3, 1'b1);
    wait_cycles(3);

    // start while busy is dropped.
    issue(ALU_DIV, 32'd100, 32'd10, 1'b0);
    issue(ALU_MUL, 32'd3, 32'd3, 1'b0);
    wait_idle();
    chk("busy_start_result", result, 32'd10);

    // Asynchronous reset mid-divide.
    issue(ALU_DIVU, 32'd50, 32'd5, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    clear_all();
    m_result = '0;
    #1;
    chk("async_rst_busy",   {31'b0, busy}, 32'd0);
    chk("async_rst_done",   {31'b0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(2);

    issue(ALU_MUL, 32'd3, 32'd4, 1'b0); wait_idle();
    chk("mul_after_rst", result, 32'd12);

    wait_cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle execution unit for the RV32M ops (ALU_MUL..ALU_REMU) that the decoder selects on OP_OP with funct7 = F7_MULDIV.
- Sits in EX beside the single-cycle ALU.
- Accepts one operation per start pulse and sequences a fixed-latency multiply or an iterative radix-2 divide.
- Raises busy to stall the pipeline, then returns a registered result with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; must match riscv_pkg::XLEN.
- MUL_CYCLES, 2, cycles from start to done for MUL/MULH/MULHSU/MULHU; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  alu_op_e  operation, sampled with start.
- rs1_val  in  XLEN  dividend / multiplicand, sampled with start.
- rs2_val  in  XLEN  divisor / multiplier, sampled with start.
- flush  in  1  abort any in-flight operation.
- busy  out  1  operation in flight; pipeline stalls EX while high.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  last completed result; held until the next done.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, iteration counter=0. Reset asserted mid-operation discards that operation; no done follows.
- Accept: start=1, busy=0, flush=0 and op is one of the 8 M ops. The accept cycle is cycle 0. start with any other op is ignored: no busy, no done. start while busy=1 is ignored.
- States: IDLE, MUL, DIV, FIXUP.
  - IDLE->MUL on accepted mul op.
  - IDLE->DIV on accepted div/rem op.
  - MUL->IDLE when its counter reaches MUL_CYCLES-1.
  - DIV->FIXUP after XLEN iterations.
  - FIXUP->IDLE.
  - Special cases go IDLE->IDLE, with result and done loaded directly.
- busy = (state != IDLE). done and result are registered and load on the edge that returns to IDLE. In the done cycle busy=0, so a new start is accepted in the done cycle (back-to-back issue).
- Multiply:
  - Operands are sign- or zero-extended to XLEN+1 bits: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU and MUL unsigned.
  - Full 2*XLEN product. MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - done in cycle MUL_CYCLES; busy high in cycles 1..MUL_CYCLES-1. With MUL_CYCLES=1, busy is never high.
- Divide:
  - Signed ops take absolute values; unsigned ops pass operands unchanged.
  - Restoring division, one quotient bit per cycle, XLEN iterations.
  - FIXUP negates the quotient if the operand signs differ (DIV). Remainder takes the dividend's sign (REM).
  - busy high in cycles 1..XLEN+1; done in cycle XLEN+2 (34 for XLEN=32).
- Special cases, detected at accept, done in cycle 1, busy never high:
  - Divisor=0: DIV/DIVU -> all ones; REM/REMU -> rs1_val.
  - Signed overflow (rs1 = 0x80000000, rs2 = -1): DIV -> 0x80000000; REM -> 0.
- flush=1: next state IDLE from any state; no done for the aborted op; result unchanged. flush and start in the same cycle: flush wins, no accept. flush in the done cycle does not cancel that done.
- Operands are held in internal registers after accept; rs1_val, rs2_val and op may change while busy.

Decomposition:
- riscv_pkg additions: muldiv_state_e (IDLE, MUL, DIV, FIXUP) and localparam DIV_CYCLES = XLEN+2.
- alu_op_e and the M-op encodings already live in riscv_pkg and are reused unchanged.
- Sub-module div_core: the iterative restoring divider datapath (partial remainder, quotient shift register, iteration counter). It has start/abort/done signals and unsigned XLEN operands.
- muldiv_unit owns the FSM, sign handling, special-case detection, the multiply pipeline and the output registers.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle 2, busy high cycle 1 only.
- Operands 0xFFFFFFFF x 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM on the same operands -> 0xFFFFFFFF. busy high cycles 1..33, done cycle 34. A new DIVU 100/7 started in that done cycle returns 14 in cycle 34 of the second op.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each has done in cycle 1, busy never high.
- DIV started, flush in cycle 10 -> busy=0 in cycle 11, no done, result keeps its prior value. start+flush together -> ignored. start while busy -> ignored; the original result is unaffected.
- rst pulsed asynchronously mid-DIV (between edges) -> busy, done and result go to 0 immediately. A subsequent MUL 3 x 4 -> 12 in cycle 2.
